note_sequencer: RTL

- Step sequencer that drives the sawtooth/ADSR voice: freq_select, note_on and note_off.
- Holds a 16-entry pattern of note codes and rests, loaded over a simple write port while idle.
- Plays the pattern at a programmable step period (25 MHz clock cycles), with a programmable gate length and optional looping.
- Sits between the control/register interface and the voice generator.

---
 rtl/note_sequencer_if.sv | 39 +++
 rtl/note_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/note_sequencer_if.sv
// Control, pattern-write and voice-output bundle for the note step sequencer.
// Latency: none, wires only.
// Backpressure: none; start/stop/wr_en and all outputs are single-cycle pulses or levels.
// Ports: master = controller side (drives start/stop/loop_en/num_steps/step_period/gate_len,
//        wr_en/wr_addr/wr_data; observes wr_ack and the voice outputs).
//        slave = sequencer (drives wr_ack, freq_select, note_on, note_off, busy, step_idx, done).
interface note_sequencer_if #(
  parameter int TW = 24,
  parameter int IW = 4
);
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [4:0]    num_steps;
  logic [TW-1:0] step_period;
  logic [TW-1:0] gate_len;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic          wr_ack;
  logic [5:0]    freq_select;
  logic          note_on;
  logic          note_off;
  logic          busy;
  logic [IW-1:0] step_idx;
  logic          done;

  modport master (
    output start, stop, loop_en, num_steps, step_period, gate_len,
    output wr_en, wr_addr, wr_data,
    input  wr_ack, freq_select, note_on, note_off, busy, step_idx, done
  );

  modport slave (
    input  start, stop, loop_en, num_steps, step_period, gate_len,
    input  wr_en, wr_addr, wr_data,
    output wr_ack, freq_select, note_on, note_off, busy, step_idx, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Step sequencer: plays a pattern of note codes/rests into the voice as freq_select + note_on/note_off.
// Latency: start accepted at edge T0 gives busy/note_on for step 0 on the following cycle; all outputs registered.
// Backpressure: none; writes are dropped (no wr_ack) while playing or when coincident with an accepted start.
// Ports: clk, reset_n (async, active-low) plus bus (note_sequencer_if.slave) carrying control, the
//        pattern write port and the voice outputs.
module note_sequencer #(
  parameter int         STEPS        = 16,
  parameter int         TW           = 24,
  parameter logic [5:0] DEFAULT_NOTE = 6'd33
) (
  input  logic clk,
  input  logic reset_n,
  note_sequencer_if.slave bus
);
  localparam int         IW     = $clog2(STEPS);
  localparam logic [4:0] STEPS5 = 5'(STEPS);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state_q, state_d;
  logic [6:0]    pattern [STEPS];
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] pm1_q, pm1_d;      // step period minus one
  logic [TW-1:0] g_q, g_d;          // gate length after clamping
  logic [IW-1:0] last_q, last_d;    // index of the final active step
  logic [IW-1:0] idx_q, idx_d;
  logic          gate_q, gate_d;
  logic [5:0]    freq_q, freq_d;
  logic          on_q, on_d, off_q, off_d, done_q, done_d, busy_q, busy_d, ack_q;

  logic          start_acc, wr_acc, new_step;
  logic [IW-1:0] step_sel;
  logic [4:0]    ns_eff;
  logic [TW-1:0] p_eff, p_eff_m1, g_raw, g_clamp;

  // stop beats start when both arrive in IDLE.
  assign start_acc = (state_q == IDLE) && bus.start && !bus.stop;
  assign wr_acc    = bus.wr_en && (state_q == IDLE) && !start_acc;

  // Playback parameter clamping, evaluated on the inputs at the start edge.
  assign ns_eff   = (bus.num_steps == 5'd0 || bus.num_steps > STEPS5) ? STEPS5 : bus.num_steps;
  assign p_eff    = (bus.step_period < TW'(2)) ? TW'(2) : bus.step_period;
  assign p_eff_m1 = p_eff - TW'(1);
  assign g_raw    = (bus.gate_len == '0) ? TW'(1) : bus.gate_len;
  assign g_clamp  = (g_raw > p_eff_m1) ? p_eff_m1 : g_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pm1_q   <= '0;
      g_q     <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      gate_q  <= 1'b0;
      freq_q  <= DEFAULT_NOTE;
      on_q    <= 1'b0;
      off_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pm1_q   <= pm1_d;
      g_q     <= g_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      gate_q  <= gate_d;
      freq_q  <= freq_d;
      on_q    <= on_d;
      off_q   <= off_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ack_q   <= wr_acc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STEPS; i++) pattern[i] <= 7'h40;
    end else if (wr_acc) begin
      pattern[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pm1_d    = pm1_q;
    g_d      = g_q;
    last_d   = last_q;
    idx_d    = idx_q;
    gate_d   = gate_q;
    freq_d   = freq_q;
    busy_d   = busy_q;
    on_d     = 1'b0;
    off_d    = 1'b0;
    done_d   = 1'b0;
    new_step = 1'b0;
    step_sel = '0;

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d  = PLAY;
          busy_d   = 1'b1;
          idx_d    = '0;
          timer_d  = '0;
          pm1_d    = p_eff_m1;
          g_d      = g_clamp;
          last_d   = IW'(ns_eff - 5'd1);
          new_step = 1'b1;
        end
      end
      PLAY: begin
        if (bus.stop) begin
          // Abort wins over advance and gate end; close an open gate exactly once.
          state_d = IDLE;
          busy_d  = 1'b0;
          idx_d   = '0;
          timer_d = '0;
          off_d   = gate_q;
          gate_d  = 1'b0;
        end else if (timer_q == pm1_q) begin
          timer_d = '0;
          if (idx_q == last_q && !bus.loop_en) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d    = (idx_q == last_q) ? '0 : idx_q + 1'b1;
            new_step = 1'b1;
            step_sel = idx_d;
          end
        end else begin
          timer_d = timer_q + TW'(1);
          // Registered so note_off is visible in the cycle whose timer equals G.
          if (gate_q && (timer_q + TW'(1)) == g_q) begin
            off_d  = 1'b1;
            gate_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Non-rest step entry: retune and trigger; rests leave freq_select alone.
    if (new_step && !pattern[step_sel][6]) begin
      freq_d = pattern[step_sel][5:0];
      on_d   = 1'b1;
      gate_d = 1'b1;
    end
  end

  assign bus.wr_ack      = ack_q;
  assign bus.freq_select = freq_q;
  assign bus.note_on     = on_q;
  assign bus.note_off    = off_q;
  assign bus.busy        = busy_q;
  assign bus.step_idx    = idx_q;
  assign bus.done        = done_q;
endmodule
